// File: rtl/masked_sub_seq.sv
// ---------------------------------------------------------------------------
// masked_sub_seq
// Purpose : sequential masked (Boolean-shared) propagate/borrow-generate
//           computation for a W-bit subtraction a - b. One 1-bit subtraction
//           gadget is time-shared across all bit positions; each bit is
//           issued once fresh randomness is available, and the results are
//           written back at their tagged index two cycles later.
// Ports   : clk, rst (async, active-high)
//           start      - request a job (accepted only in IDLE)
//           a_in, b_in - W*d shares, bit i shares at [i*d +: d]
//           rnd_in     - d*(d-1)/2 fresh random bits per gadget issue
//           rnd_valid  - rnd_in is fresh this cycle
//           rnd_ready  - rnd_in is consumed when rnd_valid is also high
//           busy, done - job status (done is a one-cycle pulse)
//           p_out      - shares of a_i XOR b_i
//           g_out      - shares of (NOT a_i) AND b_i
//           abort      - only with MASKED_SUB_SEQ_ABORT_EN defined
// Config  : MASKED_SUB_SEQ_ABORT_EN adds the abort input.
// ---------------------------------------------------------------------------

// Two-stage masked 1-bit subtraction gadget (DOM-style AND for the borrow
// generate, share-wise XOR for the propagate). Shares stay separated.
module subtraction_1bit #(
  parameter int unsigned d = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [d-1:0]           i_a,
  input  logic [d-1:0]           i_b,
  input  logic [d*(d-1)/2-1:0]   i_rnd,
  output logic [d-1:0]           o_p,
  output logic [d-1:0]           o_g
);

  // NOT of a shared value only flips share 0
  logic [d-1:0]   w_na;
  logic [d*d-1:0] w_cross;
  logic [d*d-1:0] r_cross;
  logic [d-1:0]   r_p1;
  logic [d-1:0]   w_g;

  assign w_na = i_a ^ d'(1);

  // Cross products; each off-diagonal pair shares one random bit so that the
  // random contributions cancel when the output shares are recombined.
  for (genvar gi = 0; gi < d; gi++) begin : g_row
    for (genvar gj = 0; gj < d; gj++) begin : g_col
      if (gi == gj) begin : g_diag
        assign w_cross[gi*d+gj] = w_na[gi] & i_b[gj];
      end else if (gi < gj) begin : g_up
        localparam int unsigned K = gi*d - (gi*(gi+1))/2 + (gj-gi-1);
        assign w_cross[gi*d+gj] = (w_na[gi] & i_b[gj]) ^ i_rnd[K];
      end else begin : g_lo
        localparam int unsigned K = gj*d - (gj*(gj+1))/2 + (gi-gj-1);
        assign w_cross[gi*d+gj] = (w_na[gi] & i_b[gj]) ^ i_rnd[K];
      end
    end
    // Compression happens only after the refreshed terms are registered
    assign w_g[gi] = ^r_cross[gi*d +: d];
  end

  // Stage 1: refreshed cross products and propagate shares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cross <= '0;
      r_p1    <= '0;
    end else begin
      r_cross <= w_cross;
      r_p1    <= i_a ^ i_b;
    end
  end

  // Stage 2: compressed generate shares and aligned propagate shares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_p <= '0;
      o_g <= '0;
    end else begin
      o_p <= r_p1;
      o_g <= w_g;
    end
  end

endmodule

module masked_sub_seq #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W*d-1:0]         a_in,
  input  logic [W*d-1:0]         b_in,
  input  logic [d*(d-1)/2-1:0]   rnd_in,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  output logic                   busy,
  output logic                   done,
  output logic [W*d-1:0]         p_out,
  output logic [W*d-1:0]         g_out
`ifdef MASKED_SUB_SEQ_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned RW = d*(d-1)/2;
  localparam logic [IW-1:0] LAST_IDX = IW'(W-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_abort;

  logic [W-1:0][d-1:0]  r_a;
  logic [W-1:0][d-1:0]  r_b;
  logic [W-1:0][d-1:0]  r_p;
  logic [W-1:0][d-1:0]  r_g;
  logic [IW-1:0]        r_idx;
  logic                 r_t1_vld;
  logic [IW-1:0]        r_t1_idx;
  logic                 r_t2_vld;
  logic [IW-1:0]        r_t2_idx;
  logic                 r_rnd_ready;
  logic                 r_busy;
  logic                 r_done;

  logic [d-1:0]         w_ga;
  logic [d-1:0]         w_gb;
  logic [RW-1:0]        w_grnd;
  logic [d-1:0]         w_gp;
  logic [d-1:0]         w_gg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (rnd_valid) begin
          w_issue = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!r_t1_vld && !r_t2_vld) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
`ifdef MASKED_SUB_SEQ_ABORT_EN
    if (abort && (r_state == ISSUE || r_state == DRAIN)) begin
      w_abort      = 1'b1;
      w_issue      = 1'b0;
      w_state_next = IDLE;
    end
`endif
  end

  // Gadget inputs are zeroed when not issuing so stale randomness is never
  // recombined with live shares.
  assign w_ga   = w_issue ? r_a[r_idx] : '0;
  assign w_gb   = w_issue ? r_b[r_idx] : '0;
  assign w_grnd = w_issue ? rnd_in     : '0;

  subtraction_1bit #(
    .d (d)
  ) u_gadget (
    .clk   (clk),
    .rst   (rst),
    .i_a   (w_ga),
    .i_b   (w_gb),
    .i_rnd (w_grnd),
    .o_p   (w_gp),
    .o_g   (w_gg)
  );

  // Status outputs follow the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rnd_ready <= (w_state_next == ISSUE);
      r_busy      <= (w_state_next == ISSUE) || (w_state_next == DRAIN);
      r_done      <= (w_state_next == DONE);
    end
  end

  // Operand registers and bit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_idx <= '0;
    end else if (w_abort) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
    end else if (w_issue) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  // Valid/index tag pipeline, aligned with the gadget latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t1_vld <= 1'b0;
      r_t1_idx <= '0;
      r_t2_vld <= 1'b0;
      r_t2_idx <= '0;
    end else if (w_abort) begin
      r_t1_vld <= 1'b0;
      r_t1_idx <= '0;
      r_t2_vld <= 1'b0;
      r_t2_idx <= '0;
    end else begin
      r_t1_vld <= w_issue;
      r_t1_idx <= r_idx;
      r_t2_vld <= r_t1_vld;
      r_t2_idx <= r_t1_idx;
    end
  end

  // Result vectors: cleared on accept/abort, written at the tagged index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
      r_g <= '0;
    end else if (w_accept || w_abort) begin
      r_p <= '0;
      r_g <= '0;
    end else if (r_t2_vld) begin
      r_p[r_t2_idx] <= w_gp;
      r_g[r_t2_idx] <= w_gg;
    end
  end

  assign rnd_ready = r_rnd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign p_out     = r_p;
  assign g_out     = r_g;

endmodule

// File: tb/tb_masked_sub_seq.sv
// Directed bench for masked_sub_seq: d=2 with W=4 and W=16 instances.
module tb_masked_sub_seq;

  localparam int unsigned D  = 2;
  localparam int unsigned RW = D*(D-1)/2;

  logic clk;
  logic rst;

  logic            start4, rnd_valid4, rnd_ready4, busy4, done4;
  logic [4*D-1:0]  a4, b4, p4, g4;
  logic [RW-1:0]   rnd_in4;

  logic            start16, rnd_valid16, rnd_ready16, busy16, done16;
  logic [16*D-1:0] a16, b16, p16, g16;
  logic [RW-1:0]   rnd_in16;
`ifdef MASKED_SUB_SEQ_ABORT_EN
  logic            abort4, abort16;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int hs4   = 0;

  masked_sub_seq #(.d(D), .W(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a_in      (a4),
    .b_in      (b4),
    .rnd_in    (rnd_in4),
    .rnd_valid (rnd_valid4),
    .rnd_ready (rnd_ready4),
    .busy      (busy4),
    .done      (done4),
    .p_out     (p4),
    .g_out     (g4)
`ifdef MASKED_SUB_SEQ_ABORT_EN
    ,
    .abort     (abort4)
`endif
  );

  masked_sub_seq #(.d(D), .W(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start16),
    .a_in      (a16),
    .b_in      (b16),
    .rnd_in    (rnd_in16),
    .rnd_valid (rnd_valid16),
    .rnd_ready (rnd_ready16),
    .busy      (busy16),
    .done      (done16),
    .p_out     (p16),
    .g_out     (g16)
`ifdef MASKED_SUB_SEQ_ABORT_EN
    ,
    .abort     (abort16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rnd_valid4 && rnd_ready4) hs4 <= hs4 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Random Boolean sharing of a 16-bit value
  function automatic logic [16*D-1:0] share_split(input logic [15:0] v);
    logic [16*D-1:0] r;
    logic [D-1:0]    sh;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      sh        = D'($urandom);
      sh[D-1]   = v[i] ^ (^sh[D-2:0]);
      r[i*D +: D] = sh;
    end
    return r;
  endfunction

  function automatic logic [15:0] unmask(input logic [16*D-1:0] s);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = ^s[i*D +: D];
    return v;
  endfunction

  function automatic logic [4*D-1:0] split4(input logic [3:0] v);
    logic [16*D-1:0] t;
    t = share_split({12'h000, v});
    return t[4*D-1:0];
  endfunction

  // One W=4 job; optional randomness stall after bit stall_at and a
  // second start pulse while the job is running.
  task automatic job4(input logic [3:0] av, input logic [3:0] bv,
                      input int stall_at, input int stall_n, input bit restart,
                      output int lat, output bit busy_ok, output int hs);
    int hs0;
    int stall_left;
    a4 = split4(av);
    b4 = split4(bv);
    start4 = 1'b1;
    rnd_valid4 = 1'b1;
    rnd_in4 = RW'($urandom);
    @(posedge clk); #1;
    start4 = 1'b0;
    hs0 = hs4;
    check("p_clear_on_accept", 64'(p4), 64'd0);
    lat = -1;
    busy_ok = 1'b1;
    stall_left = stall_n;
    for (int k = 1; k <= 40; k++) begin
      if (restart && k == 2) begin
        start4 = 1'b1;
        a4 = split4(4'b1111);
        b4 = split4(4'b0000);
      end else begin
        start4 = 1'b0;
      end
      rnd_in4 = RW'($urandom);
      if (stall_left > 0 && (hs4 - hs0) == stall_at) begin
        rnd_valid4 = 1'b0;
        stall_left--;
      end else begin
        rnd_valid4 = 1'b1;
      end
      @(posedge clk); #1;
      if (done4) begin
        lat = k;
        break;
      end
      if (!busy4) busy_ok = 1'b0;
    end
    start4 = 1'b0;
    hs = hs4 - hs0;
  endtask

  task automatic job16(input logic [15:0] av, input logic [15:0] bv, output int lat);
    a16 = share_split(av);
    b16 = share_split(bv);
    start16 = 1'b1;
    rnd_valid16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      rnd_in16 = RW'($urandom);
      @(posedge clk); #1;
      if (done16) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  bok;
    int  hs;
    rst = 1'b1;
    start4 = 1'b0; rnd_valid4 = 1'b0; rnd_in4 = '0; a4 = '0; b4 = '0;
    start16 = 1'b0; rnd_valid16 = 1'b0; rnd_in16 = '0; a16 = '0; b16 = '0;
`ifdef MASKED_SUB_SEQ_ABORT_EN
    abort4 = 1'b0; abort16 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_done", 64'(done4), 64'd0);
    check("rst_rnd_ready", 64'(rnd_ready4), 64'd0);
    check("rst_p", 64'(p4), 64'd0);
    check("rst_g", 64'(g4), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic job with continuous randomness
    job4(4'b0110, 4'b0011, 0, 0, 1'b0, lat, bok, hs);
    check("basic_latency", 64'(lat), 64'd7);
    check("basic_p", 64'(unmask({24'd0, p4})), 64'h5);
    check("basic_g", 64'(unmask({24'd0, g4})), 64'h1);
    check("basic_busy_held", 64'(bok), 64'd1);
    check("basic_busy_at_done", 64'(busy4), 64'd0);
    check("basic_handshakes", 64'(hs), 64'd4);
    // start during the DONE cycle must be ignored
    start4 = 1'b1;
    a4 = split4(4'b1111);
    @(posedge clk); #1;
    start4 = 1'b0;
    check("done_one_cycle", 64'(done4), 64'd0);
    @(posedge clk); #1;
    check("start_in_done_ignored", 64'(busy4), 64'd0);
    check("hold_p", 64'(unmask({24'd0, p4})), 64'h5);
    check("hold_g", 64'(unmask({24'd0, g4})), 64'h1);

    // Randomness stall after bit 1 for three cycles
    job4(4'b0110, 4'b0011, 2, 3, 1'b0, lat, bok, hs);
    check("stall_latency", 64'(lat), 64'd10);
    check("stall_p", 64'(unmask({24'd0, p4})), 64'h5);
    check("stall_g", 64'(unmask({24'd0, g4})), 64'h1);
    check("stall_handshakes", 64'(hs), 64'd4);
    @(posedge clk); #1;

    // Second start while busy is ignored
    job4(4'b0110, 4'b0011, 0, 0, 1'b1, lat, bok, hs);
    check("restart_latency", 64'(lat), 64'd7);
    check("restart_p", 64'(unmask({24'd0, p4})), 64'h5);
    check("restart_g", 64'(unmask({24'd0, g4})), 64'h1);
    check("restart_busy_held", 64'(bok), 64'd1);
    @(posedge clk); #1;

    // Reset two cycles after acceptance
    a4 = split4(4'b1111);
    b4 = split4(4'b0000);
    start4 = 1'b1;
    rnd_valid4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy4), 64'd0);
    check("midrst_ready", 64'(rnd_ready4), 64'd0);
    check("midrst_p", 64'(p4), 64'd0);
    check("midrst_g", 64'(g4), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_capture", 64'(p4), 64'd0);
    check("midrst_no_done", 64'(done4), 64'd0);
    job4(4'b1010, 4'b0101, 0, 0, 1'b0, lat, bok, hs);
    check("fresh_latency", 64'(lat), 64'd7);
    check("fresh_p", 64'(unmask({24'd0, p4})), 64'hF);
    check("fresh_g", 64'(unmask({24'd0, g4})), 64'h5);
    @(posedge clk); #1;
    job4(4'b0011, 4'b0110, 0, 0, 1'b0, lat, bok, hs);
    check("swap_p", 64'(unmask({24'd0, p4})), 64'h5);
    check("swap_g", 64'(unmask({24'd0, g4})), 64'h4);
    @(posedge clk); #1;

`ifdef MASKED_SUB_SEQ_ABORT_EN
    // Abort while draining
    a4 = split4(4'b0110);
    b4 = split4(4'b0011);
    start4 = 1'b1;
    rnd_valid4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort4 = 1'b1;
    @(posedge clk); #1;
    abort4 = 1'b0;
    check("abort_busy", 64'(busy4), 64'd0);
    check("abort_done", 64'(done4), 64'd0);
    check("abort_p", 64'(p4), 64'd0);
    check("abort_g", 64'(g4), 64'd0);
    bok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done4) bok = 1'b0;
    end
    check("abort_no_done_later", 64'(bok), 64'd1);
`endif

    // Wide operands
    job16(16'hFFFF, 16'h0000, lat);
    check("w16_a_latency", 64'(lat), 64'd19);
    check("w16_a_p", 64'(unmask(p16)), 64'hFFFF);
    check("w16_a_g", 64'(unmask(g16)), 64'h0000);
    @(posedge clk); #1;
    job16(16'h0000, 16'hFFFF, lat);
    check("w16_b_latency", 64'(lat), 64'd19);
    check("w16_b_p", 64'(unmask(p16)), 64'hFFFF);
    check("w16_b_g", 64'(unmask(g16)), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/masked_sub_seq.md
MASKED_SUB_SEQ -- requirements
Module: masked_sub_seq

Interface
REQ-001 Parameter d, default 2, number of Boolean shares per bit (d >= 2).
REQ-002 Parameter W, default 16, operand width in bits (2 <= W <= 64).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a new W-bit masked subtraction; accepted only in IDLE.
REQ-006 a_in  input  W*d  minuend, bit i shares at [i*d +: d].
REQ-007 b_in  input  W*d  subtrahend, same share layout as a_in.
REQ-008 rnd_in  input  d*(d-1)/2  fresh randomness for one gadget issue.
REQ-009 rnd_valid  input  1  rnd_in holds unused randomness this cycle.
REQ-010 rnd_ready  output  1  rnd_in consumed this cycle (rnd_valid and rnd_ready both high).
REQ-011 busy  output  1  high from start acceptance until the cycle done is asserted.
REQ-012 done  output  1  one-cycle pulse when p_out/g_out are complete.
REQ-013 p_out  output  W*d  masked propagate vector, bit i = a_i XOR b_i (shares).
REQ-014 g_out  output  W*d  masked borrow-generate vector, bit i = NOT a_i AND b_i (shares).

Function
REQ-015 Block SHALL contain exactly one subtraction_1bit instance (d shares) shared across all W bit positions; no other nonlinear gadget.
REQ-016 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: start high latches a_in/b_in into operand registers, clears bit index to 0, sets busy, moves to ISSUE.
REQ-018 ISSUE: rnd_ready = 1; on a cycle with rnd_valid high, bit index i SHALL be driven onto gadget a/b inputs with rnd_in, a 2-stage valid/index tag entered, and i incremented.
REQ-019 ISSUE with rnd_valid low: no gadget issue, tag bubble inserted, index held (stall, no loss or duplication).
REQ-020 After issuing index W-1 the FSM SHALL move to DRAIN; rnd_ready low in all states except ISSUE.
REQ-021 Gadget latency is fixed at 2 cycles; a and b shares of one bit SHALL be presented in the same cycle; the result tagged valid at tag stage 2 SHALL be written to p_out/g_out at its tagged index.
REQ-022 DRAIN: move to DONE when both tag stages are empty.
REQ-023 DONE: done = 1 for exactly one cycle, busy cleared, return to IDLE.
REQ-024 With rnd_valid constantly high, done SHALL assert exactly W+3 cycles after the start-acceptance edge (W=16: 19).
REQ-025 p_out/g_out SHALL hold their values from done until the next start acceptance, then are cleared to zero at acceptance.
REQ-026 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-027 Shares SHALL never be combined inside the block; only share-wise routing and registers outside the gadget.

Reset
REQ-028 rst high SHALL force state IDLE, busy 0, done 0, rnd_ready 0, p_out 0, g_out 0, operand registers 0, tags empty, index 0.
REQ-029 Reset mid-operation abandons the job; in-flight gadget results SHALL NOT be captured afterwards (tags cleared).

Configuration
REQ-030 Macro MASKED_SUB_SEQ_ABORT_EN defined: extra input abort (1 bit); abort high in ISSUE or DRAIN SHALL clear operand registers, tags, p_out, g_out, busy, and return to IDLE next cycle without done.
REQ-031 Macro undefined: no abort port; a job always runs to DONE.

Verification
REQ-032 d=2, W=4, a=0110, b=0011 (random share splits), rnd_valid=1 -> done at +7 cycles; unmasked p_out=0101, g_out=0001.
REQ-033 Same operands, rnd_valid low for 3 cycles after bit 1 -> done at +10 cycles, identical unmasked results, exactly 4 rnd handshakes.
REQ-034 start pulsed again during ISSUE with different operands -> ignored; results match first operands; busy stays high until done.
REQ-035 rst asserted two cycles after start -> next edge IDLE, all outputs 0; a fresh job then completes correctly.
REQ-036 MASKED_SUB_SEQ_ABORT_EN, abort in DRAIN -> no done pulse, p_out=g_out=0, IDLE next cycle; without macro, build lacks abort port.
REQ-037 W=16, a=0xFFFF, b=0x0000, then a=0x0000, b=0xFFFF -> unmasked p_out=0xFFFF both jobs; g_out=0x0000 then 0xFFFF.
